// File: rtl/mem_pkg.sv
// Shared types and defaults for the stalling data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WORD_BITS     = 16;
    localparam int DEF_LATENCY   = 4;
    localparam int DEF_ADDR_BITS = 8;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, asynchronous read, synchronous clear.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] widx,
    input  logic [WORD_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] ridx,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [2**ADDR_BITS];

    // Clear wins over write so a commit landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: clearing every word forces flop-based storage; a RAM macro cannot be reset in one cycle.
            for (int i = 0; i < 2**ADDR_BITS; i++) begin
                // NOTE: non-blocking assignments keep every flop update ordered against the same sampled edge.
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/stall_mem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls while busy,
// pulses done after LATENCY cycles (write committed / read data valid).
module stall_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY   = DEF_LATENCY,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 wr,
    input  logic [15:0]          addr,
    input  logic [WORD_BITS-1:0] data_in,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 stall,
    output logic                 done,
    output logic                 err
);

    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

    state_t                 state, state_next;
    logic [3:0]             cnt, cnt_next;
    logic [ADDR_BITS-1:0]   lat_idx, lat_idx_next;
    logic                   lat_wr, lat_wr_next;
    logic [WORD_BITS-1:0]   lat_data, lat_data_next;
    logic                   stall_next, err_next, done_next;
    logic [WORD_BITS-1:0]   dout_next;

    // Transaction that completes on the coming edge (latched, or the input itself when LATENCY=1).
    logic [ADDR_BITS-1:0]   tgt_idx;
    logic                   tgt_wr;
    logic [WORD_BITS-1:0]   tgt_data;

    logic                   mem_we;
    logic [WORD_BITS-1:0]   mem_rdata;
    logic                   unused_addr_bits;

    // Upper address bits alias; bit 0 only feeds the alignment check.
    assign unused_addr_bits = ^addr[15:ADDR_BITS+1];

    // Next-state, counter and request latching.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the block leaves one unassigned (no latches).
        state_next    = state;
        cnt_next      = cnt;
        lat_idx_next  = lat_idx;
        lat_wr_next   = lat_wr;
        lat_data_next = lat_data;
        stall_next    = 1'b0;
        err_next      = 1'b0;
        tgt_idx       = lat_idx;
        tgt_wr        = lat_wr;
        tgt_data      = lat_data;

        case (state)
            BUSY: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_next = DONE;
                end else begin
                    stall_next = 1'b1;
                end
            end
            default: begin
                // IDLE, DONE (and the unused encoding) all accept requests.
                state_next = IDLE;
                // Simulation-only X detection; folds to constant 0 in hardware.
                if ($isunknown({enable, wr})) begin
                    err_next = 1'b1;
                end else if (enable) begin
                    if (addr[0]) begin
                        err_next = 1'b1;
                    end else begin
                        lat_idx_next  = addr[ADDR_BITS:1];
                        lat_wr_next   = wr;
                        lat_data_next = data_in;
                        tgt_idx       = addr[ADDR_BITS:1];
                        tgt_wr        = wr;
                        tgt_data      = data_in;
                        cnt_next      = LOAD;
                        if (LATENCY == 1) begin
                            state_next = DONE;
                        end else begin
                            state_next = BUSY;
                            stall_next = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // Completion: commit the write or fetch read data on the edge entering DONE.
    always_comb begin
        done_next = 1'b0;
        mem_we    = 1'b0;
        dout_next = '0;
        if (state_next == DONE) begin
            done_next = 1'b1;
            mem_we    = tgt_wr;
            if (!tgt_wr) begin
                dout_next = mem_rdata;
            end
        end
    end

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .clr   (!rst),
        .we    (mem_we),
        .widx  (tgt_idx),
        .wdata (tgt_data),
        .ridx  (tgt_idx),
        .rdata (mem_rdata)
    );

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_idx  <= '0;
            lat_wr   <= 1'b0;
            lat_data <= '0;
            stall    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            lat_idx  <= lat_idx_next;
            lat_wr   <= lat_wr_next;
            lat_data <= lat_data_next;
            stall    <= stall_next;
            done     <= done_next;
            err      <= err_next;
            data_out <= dout_next;
        end
    end

endmodule

// File: tb/tb_stall_mem_responder.sv
// Self-checking bench: LATENCY=4 and LATENCY=1 instances driven by the same
// stimulus, compared every cycle against a transaction-schedule reference model.
module tb_stall_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;

    logic [15:0] dout4, dout1;
    logic        stall4, done4, err4;
    logic        stall1, done1, err1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stall_mem_responder #(.LATENCY(4), .ADDR_BITS(8)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (dout4),
        .stall    (stall4),
        .done     (done4),
        .err      (err4)
    );

    stall_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (dout1),
        .stall    (stall1),
        .done     (done1),
        .err      (err1)
    );

    // Reference model: per instance, a word array plus the edge number at which
    // the outstanding request completes. Index 0 = LATENCY 4, index 1 = LATENCY 1.
    int          lat_of [2];
    logic [15:0] mm     [2][256];
    bit          pend   [2];
    longint      done_edge [2];
    bit          p_wr   [2];
    logic [7:0]  p_idx  [2];
    logic [15:0] p_data [2];
    logic        e_stall [2];
    logic        e_done  [2];
    logic        e_err   [2];
    logic [15:0] e_dout  [2];
    longint      edge_n = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic w,
                              input logic [15:0] a, input logic [15:0] d);
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            e_stall[k] = 1'b0;
            e_done[k]  = 1'b0;
            e_err[k]   = 1'b0;
            e_dout[k]  = 16'h0000;
            if (!r) begin
                for (int j = 0; j < 256; j++) mm[k][j] = 16'h0000;
                pend[k] = 1'b0;
            end else begin
                if (!(pend[k] && edge_n <= done_edge[k])) begin
                    pend[k] = 1'b0;
                    if (e) begin
                        if (a[0]) begin
                            e_err[k] = 1'b1;
                        end else begin
                            pend[k]      = 1'b1;
                            done_edge[k] = edge_n + longint'(lat_of[k]) - 1;
                            p_wr[k]      = w;
                            p_idx[k]     = a[8:1];
                            p_data[k]    = d;
                        end
                    end
                end
                if (pend[k] && done_edge[k] == edge_n) begin
                    e_done[k] = 1'b1;
                    if (p_wr[k]) mm[k][p_idx[k]] = p_data[k];
                    else         e_dout[k] = mm[k][p_idx[k]];
                end
                e_stall[k] = pend[k] && (edge_n < done_edge[k]);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare #1 later.
    task automatic cycle(input logic r, input logic e, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        rst = r; enable = e; wr = w; addr = a; data_in = d;
        @(posedge clk);
        model_edge(r, e, w, a, d);
        #1;
        check("L4.stall", {15'b0, stall4}, {15'b0, e_stall[0]});
        check("L4.done",  {15'b0, done4},  {15'b0, e_done[0]});
        check("L4.err",   {15'b0, err4},   {15'b0, e_err[0]});
        check("L4.data",  dout4,           e_dout[0]);
        check("L1.stall", {15'b0, stall1}, {15'b0, e_stall[1]});
        check("L1.done",  {15'b0, done1},  {15'b0, e_done[1]});
        check("L1.err",   {15'b0, err1},   {15'b0, e_err[1]});
        check("L1.data",  dout1,           e_dout[1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        lat_of[0] = 4;
        lat_of[1] = 1;
        for (int k = 0; k < 2; k++) pend[k] = 1'b0;
        rst = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        #2;

        // Reset then read of a cleared word.
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("rst.stall", {15'b0, stall4}, 16'h0000);
        check("rst.data",  dout4,           16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        check("rd0.stall1", {15'b0, stall4}, 16'h0001);
        check("L1.no_stall", {15'b0, stall1}, 16'h0000);
        check("L1.done_next", {15'b0, done1}, 16'h0001);
        idle(2);
        check("rd0.stall3", {15'b0, stall4}, 16'h0001);
        idle(1);
        check("rd0.done", {15'b0, done4}, 16'h0001);
        check("rd0.data", dout4, 16'h0000);

        // Write then back-to-back read issued in the DONE cycle.
        cycle(1'b1, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
        idle(3);
        check("wr.done", {15'b0, done4}, 16'h0001);
        check("wr.data", dout4, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(3);
        check("rdw.done", {15'b0, done4}, 16'h0001);
        check("rdw.data", dout4, 16'hBEEF);

        // Unaligned request: err pulse only.
        cycle(1'b1, 1'b1, 1'b1, 16'h0021, 16'h5555);
        check("unal.err",  {15'b0, err4},  16'h0001);
        check("unal.done", {15'b0, done4}, 16'h0000);
        idle(1);
        check("unal.err_clear", {15'b0, err4}, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(3);
        check("unal.rd", dout4, 16'hBEEF);

        // Requests while busy are ignored by the LATENCY=4 instance.
        cycle(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 16'h0040, 16'h1234);
        cycle(1'b1, 1'b1, 1'b1, 16'h0040, 16'h1234);
        idle(2);
        cycle(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        idle(3);
        check("busy.rd", dout4, 16'h0000);
        idle(1);

        // Reset in the middle of a write.
        cycle(1'b1, 1'b1, 1'b1, 16'h0002, 16'hAAAA);
        idle(1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("mid.stall", {15'b0, stall4}, 16'h0000);
        check("mid.done",  {15'b0, done4},  16'h0000);
        idle(4);
        cycle(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
        idle(3);
        check("mid.rd", dout4, 16'h0000);
        idle(1);

        // Address aliasing: 0x0202 and 0x0002 are the same word.
        cycle(1'b1, 1'b1, 1'b1, 16'h0202, 16'h7777);
        idle(4);
        cycle(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
        idle(3);
        check("alias.rd", dout4, 16'h7777);

        // Randomized traffic with occasional unaligned requests and resets.
        for (int i = 0; i < 3000; i++) begin
            logic        r_r, r_e, r_w;
            logic [15:0] r_a, r_d;
            r_r = ($urandom_range(0, 99) != 0);
            r_e = ($urandom_range(0, 1) == 1);
            r_w = ($urandom_range(0, 1) == 1);
            r_a = {7'($urandom), 5'($urandom_range(0, 1) * 16), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) == 0)};
            r_d = 16'($urandom);
            cycle(r_r, r_e, r_w, r_a, r_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stall_mem_responder.md
Name: stall_mem_responder

Overview:
- Memory-side responder for the data-memory request interface driven by the processor's memory stage (enable / wr / addr / data_in -> data_out).
- Unlike the single-cycle perfect memory, it models a realistic multi-cycle memory: it accepts one request, raises stall while busy, and pulses done when read data is valid or the write has been committed.
- Replaces the perfect data memory in the multi-cycle processor so that stall handling in the pipeline can be exercised.

Parameters:
LATENCY, 4, cycles from request acceptance to the done pulse; legal range 1..15.
ADDR_BITS, 8, word-address width; memory holds 2**ADDR_BITS 16-bit words.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-low reset (0 = reset).
enable  input  1  request valid; sampled only when stall=0.
wr  input  1  1 = write, 0 = read; sampled with enable.
addr  input  16  byte address; word index = addr[ADDR_BITS:1].
data_in  input  16  write data; sampled with enable.
data_out  output  16  read data; valid only while done=1.
stall  output  1  1 = busy, new requests are ignored.
done  output  1  one-cycle pulse marking completion of the accepted request.
err  output  1  one-cycle pulse flagging an unaligned request (addr[0]=1).

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to IDLE; stall=0, done=0, err=0, data_out=0; latency counter = 0.
  - All memory words are cleared to 0.
  - Takes effect mid-operation: an in-flight request is abandoned, and an uncommitted write is never committed.
- FSM states: IDLE, BUSY, DONE.
- Accept condition: state in {IDLE, DONE} and enable=1 and addr[0]=0.
  - On accept, latch addr word index, wr and data_in.
  - Load counter = LATENCY-1.
  - Next state = BUSY, or DONE directly if LATENCY=1.
- Unaligned request: state in {IDLE, DONE}, enable=1, addr[0]=1.
  - err=1 in the next cycle, for one cycle.
  - No memory access, no done; next state = IDLE.
- BUSY:
  - stall=1, done=0.
  - Counter decrements each cycle; when counter = 1 at an edge, next state = DONE.
  - enable, addr, wr and data_in are ignored; the requester is not required to hold them.
- DONE (exactly one cycle):
  - done=1, stall=0.
  - Read: data_out = mem[latched index].
  - Write: data_out = 0; the write is committed on the edge that enters DONE.
  - A new request may be accepted in the DONE cycle, giving back-to-back service with no IDLE gap.
  - With no new request, next state = IDLE.
- Latency: done is asserted exactly LATENCY cycles after the accepting edge.
  - A read issued in the cycle after a write's done returns the new data.
- Registered outputs: stall, done, err and data_out are registered; no combinational path from inputs to outputs.
- Outside DONE, data_out = 0.
- Address aliasing: addr bits above ADDR_BITS are ignored (wrap/alias).
- Undefined inputs: enable or wr = X while stall=0 raises err and is treated as no request.

Decomposition:
- Shared package (mem_pkg): FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), the 16-bit word width constant, and the LATENCY/ADDR_BITS defaults.
- One natural sub-module: mem_array, a synchronous-write, asynchronous-read word array with a synchronous clear, instantiated once.
- FSM and counter live in the top level.

Test Plan:
- Reset then read: rst=0 for 2 cycles, then release; read addr=0x0010 -> stall=1 for cycles 1..3, done=1 at cycle 4, data_out=0x0000.
- Write then read: write 0xBEEF to 0x0020 -> done after 4 cycles, data_out=0; read 0x0020 issued in the DONE cycle -> done 4 cycles later with data_out=0xBEEF (back-to-back, no IDLE gap).
- Unaligned access: enable=1, wr=1, addr=0x0021 -> err=1 for one cycle, no done; a subsequent read of 0x0020 returns the previous value.
- Requests while busy: during BUSY, drive enable=1, wr=1, addr=0x0040, data_in=0x1234 -> ignored; a later read of 0x0040 returns 0x0000.
- Reset mid-operation: write 0xAAAA to 0x0002, assert rst=0 at cycle 2 of BUSY -> no done, stall=0 next cycle; read 0x0002 returns 0x0000.
- Parameter sweep: LATENCY=1 -> done one cycle after acceptance and stall never asserted; ADDR_BITS=8 with addr=0x0202 aliases to word 1 (same as 0x0002).
